// File: rtl/spu_adsr_voice_state_pkg.sv
// Shared definitions for the SPU ADSR voice state bank.
// Holds the ADSR phase encoding, the countdown reload marker and the
// stored field widths used by the top and the per-voice entry.
package spu_adsr_voice_state_pkg;

  localparam int ADSR_VOL_W = 15;
  localparam int ADSR_CYC_W = 23;

  typedef enum logic [1:0] {
    ADSR_ATTACK  = 2'd0,
    ADSR_DECAY   = 2'd1,
    ADSR_SUSTAIN = 2'd2,
    ADSR_RELEASE = 2'd3
  } adsr_state_e;

  // A countdown at this value makes the update stage reload it on its next visit.
  localparam logic [ADSR_CYC_W-1:0] CHANGE_ADSR_AT = 23'd1;

endpackage

// File: rtl/spu_adsr_voice_state_entry.sv
// One voice of the ADSR state bank: KON-pending, volume, phase, countdown.
// Resolves priority between CPU key events and update-stage write-back.
// Ports:
//   clk, rst            clock, async active-high reset
//   kon, koff           key-on / key-off hit for this voice (already qualified)
//   wb                  write-back targets this voice
//   upd_vol, upd_state  write-back field enables; clear_kon clears KON-pending
//   wb_state/vol/cycle  write-back data
//   nxt_*               value the entry holds after the coming edge
//                       (feeds the read muxes for write-through)
module spu_adsr_voice_state_entry
  import spu_adsr_voice_state_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kon,
  input  logic                  koff,
  input  logic                  wb,
  input  logic                  upd_vol,
  input  logic                  upd_state,
  input  logic                  clear_kon,
  input  logic [1:0]            wb_state,
  input  logic [ADSR_VOL_W-1:0] wb_vol,
  input  logic [ADSR_CYC_W-1:0] wb_cycle,
  output logic                  nxt_kon,
  output logic [ADSR_VOL_W-1:0] nxt_vol,
  output logic [1:0]            nxt_state,
  output logic [ADSR_CYC_W-1:0] nxt_cycle
);

  logic                  kon_q;
  logic [ADSR_VOL_W-1:0] vol_q;
  logic [1:0]            state_q;
  logic [ADSR_CYC_W-1:0] cycle_q;

  // Key-off beats key-on; any key event drops the write-back entirely.
  always_comb begin
    nxt_kon   = kon_q;
    nxt_vol   = vol_q;
    nxt_state = state_q;
    nxt_cycle = cycle_q;
    if (koff) begin
      nxt_kon   = 1'b0;
      nxt_state = ADSR_RELEASE;
      nxt_cycle = CHANGE_ADSR_AT;
    end else if (kon) begin
      nxt_kon   = 1'b1;
      nxt_state = ADSR_ATTACK;
      nxt_vol   = '0;
      nxt_cycle = CHANGE_ADSR_AT;
    end else if (wb) begin
      // The update stage always supplies the already-decremented count.
      nxt_cycle = wb_cycle;
      if (upd_vol)   nxt_vol   = wb_vol;
      if (upd_state) nxt_state = wb_state;
      if (clear_kon) nxt_kon   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kon_q   <= 1'b0;
      vol_q   <= '0;
      state_q <= ADSR_RELEASE;
      cycle_q <= '0;
    end else begin
      kon_q   <= nxt_kon;
      vol_q   <= nxt_vol;
      state_q <= nxt_state;
      cycle_q <= nxt_cycle;
    end
  end

endmodule

// File: rtl/spu_adsr_voice_state.sv
// Per-voice ADSR state bank feeding the SPU envelope update stage.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_reg_SPUEnable         SPU master enable (gates key-on only)
//   i_rdVoice               voice read for the update stage (1-cycle latency)
//   i_konWrite/i_koffWrite  CPU key events, i_keyMask selects voices
//   i_wbValid, i_wbVoice    update-stage write-back strobe and voice
//   i_updateADSRVolReg, i_updateADSRState, i_clearKON, i_nextAdsr*  write-back data
//   o_curr_*                registered read of i_rdVoice, write-through
//   i_cpuRdVoice, o_cpuAdsrVol  CPU volume readback, present only when
//                           SPU_ADSR_CPU_READBACK_EN is defined (else tied 0)
module spu_adsr_voice_state
  import spu_adsr_voice_state_pkg::*;
#(
  parameter int NVOICES = 24,
  parameter int VIDXW   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_reg_SPUEnable,
  input  logic [VIDXW-1:0]      i_rdVoice,
  input  logic                  i_konWrite,
  input  logic                  i_koffWrite,
  input  logic [NVOICES-1:0]    i_keyMask,
  input  logic                  i_wbValid,
  input  logic [VIDXW-1:0]      i_wbVoice,
  input  logic                  i_updateADSRVolReg,
  input  logic                  i_updateADSRState,
  input  logic                  i_clearKON,
  input  logic [1:0]            i_nextAdsrState,
  input  logic [ADSR_VOL_W-1:0] i_nextAdsrVol,
  input  logic [ADSR_CYC_W-1:0] i_nextAdsrCycle,
  output logic                  o_curr_KON,
  output logic [ADSR_VOL_W-1:0] o_curr_AdsrVOL,
  output logic [1:0]            o_curr_AdsrState,
  output logic [ADSR_CYC_W-1:0] o_curr_AdsrCycleCount,
  output logic [ADSR_VOL_W-1:0] o_cpuAdsrVol,
  input  logic [VIDXW-1:0]      i_cpuRdVoice
);

  logic                  nxt_kon   [NVOICES];
  logic [ADSR_VOL_W-1:0] nxt_vol   [NVOICES];
  logic [1:0]            nxt_state [NVOICES];
  logic [ADSR_CYC_W-1:0] nxt_cycle [NVOICES];

  for (genvar v = 0; v < NVOICES; v++) begin : g_voice
    logic kon_hit;
    logic koff_hit;
    logic wb_hit;

    assign kon_hit  = i_konWrite && i_reg_SPUEnable && i_keyMask[v];
    assign koff_hit = i_koffWrite && i_keyMask[v];
    // Out-of-range write-back voices match no entry and are dropped here.
    assign wb_hit   = i_wbValid && (i_wbVoice == VIDXW'(v));

    spu_adsr_voice_state_entry u_entry (
      .clk       (i_clk),
      .rst       (i_rst),
      .kon       (kon_hit),
      .koff      (koff_hit),
      .wb        (wb_hit),
      .upd_vol   (i_updateADSRVolReg),
      .upd_state (i_updateADSRState),
      .clear_kon (i_clearKON),
      .wb_state  (i_nextAdsrState),
      .wb_vol    (i_nextAdsrVol),
      .wb_cycle  (i_nextAdsrCycle),
      .nxt_kon   (nxt_kon[v]),
      .nxt_vol   (nxt_vol[v]),
      .nxt_state (nxt_state[v]),
      .nxt_cycle (nxt_cycle[v])
    );
  end

  logic rd_ok;
  assign rd_ok = (i_rdVoice < VIDXW'(NVOICES));

  // Reading the entries' next values gives write-through for free.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_curr_KON            <= 1'b0;
      o_curr_AdsrVOL        <= '0;
      o_curr_AdsrState      <= ADSR_RELEASE;
      o_curr_AdsrCycleCount <= '0;
    end else if (rd_ok) begin
      o_curr_KON            <= nxt_kon[i_rdVoice];
      o_curr_AdsrVOL        <= nxt_vol[i_rdVoice];
      o_curr_AdsrState      <= nxt_state[i_rdVoice];
      o_curr_AdsrCycleCount <= nxt_cycle[i_rdVoice];
    end else begin
      o_curr_KON            <= 1'b0;
      o_curr_AdsrVOL        <= '0;
      o_curr_AdsrState      <= ADSR_RELEASE;
      o_curr_AdsrCycleCount <= '0;
    end
  end

`ifdef SPU_ADSR_CPU_READBACK_EN
  logic cpu_rd_ok;
  assign cpu_rd_ok = (i_cpuRdVoice < VIDXW'(NVOICES));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          o_cpuAdsrVol <= '0;
    else if (cpu_rd_ok) o_cpuAdsrVol <= nxt_vol[i_cpuRdVoice];
    else                o_cpuAdsrVol <= '0;
  end
`else
  logic unused_cpu_rd_voice;
  assign unused_cpu_rd_voice = ^i_cpuRdVoice;
  assign o_cpuAdsrVol        = '0;
`endif

endmodule

// File: tb/tb_spu_adsr_voice_state.sv
module tb_spu_adsr_voice_state;
  localparam int NV = 24;
  localparam int VW = 5;
  localparam logic [22:0] CHG = 23'd1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  rd_voice;
  logic        kon_w, koff_w;
  logic [23:0] key_mask;
  logic        wb_valid;
  logic [4:0]  wb_voice;
  logic        upd_vol, upd_state, clr_kon;
  logic [1:0]  n_state;
  logic [14:0] n_vol;
  logic [22:0] n_cycle;
  logic        o_kon;
  logic [14:0] o_vol;
  logic [1:0]  o_state;
  logic [22:0] o_cycle;
  logic [14:0] o_cpu_vol;
  logic [4:0]  cpu_rd;

  int tests = 0;
  int fails = 0;

  // Reference bank: what each voice holds, by the behavioural rules.
  bit          m_kon   [NV];
  int unsigned m_vol   [NV];
  int unsigned m_state [NV];
  int unsigned m_cycle [NV];
  int unsigned e_kon, e_vol, e_state, e_cycle, e_cpu;

  always #5 clk = ~clk;

  spu_adsr_voice_state #(.NVOICES(NV), .VIDXW(VW)) dut (
    .i_clk                 (clk),
    .i_rst                 (rst),
    .i_reg_SPUEnable       (en),
    .i_rdVoice             (rd_voice),
    .i_konWrite            (kon_w),
    .i_koffWrite           (koff_w),
    .i_keyMask             (key_mask),
    .i_wbValid             (wb_valid),
    .i_wbVoice             (wb_voice),
    .i_updateADSRVolReg    (upd_vol),
    .i_updateADSRState     (upd_state),
    .i_clearKON            (clr_kon),
    .i_nextAdsrState       (n_state),
    .i_nextAdsrVol         (n_vol),
    .i_nextAdsrCycle       (n_cycle),
    .o_curr_KON            (o_kon),
    .o_curr_AdsrVOL        (o_vol),
    .o_curr_AdsrState      (o_state),
    .o_curr_AdsrCycleCount (o_cycle),
    .o_cpuAdsrVol          (o_cpu_vol),
    .i_cpuRdVoice          (cpu_rd)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    kon_w = 0; koff_w = 0; key_mask = '0;
    wb_valid = 0; wb_voice = '0; upd_vol = 0; upd_state = 0; clr_kon = 0;
    n_state = '0; n_vol = '0; n_cycle = '0;
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_kon[v] = 0; m_vol[v] = 0; m_state[v] = 3; m_cycle[v] = 0;
    end
  endtask

  // Apply one cycle of events to the reference bank.
  task automatic model_apply();
    for (int v = 0; v < NV; v++) begin
      bit off_v, on_v, wb_v;
      off_v = koff_w && key_mask[v];
      on_v  = kon_w && en && key_mask[v];
      wb_v  = wb_valid && (int'(wb_voice) == v);
      if (off_v) begin
        m_state[v] = 3; m_cycle[v] = CHG; m_kon[v] = 0;
      end else if (on_v) begin
        m_kon[v] = 1; m_state[v] = 0; m_vol[v] = 0; m_cycle[v] = CHG;
      end else if (wb_v) begin
        m_cycle[v] = n_cycle;
        if (upd_vol)   m_vol[v]   = n_vol;
        if (upd_state) m_state[v] = n_state;
        if (clr_kon)   m_kon[v]   = 0;
      end
    end
  endtask

  // One clock: update model, advance DUT, compare all outputs.
  task automatic step();
    if (rst) model_reset();
    else model_apply();
    if (rst || int'(rd_voice) >= NV) begin
      e_kon = 0; e_vol = 0; e_state = 3; e_cycle = 0;
    end else begin
      e_kon = m_kon[rd_voice]; e_vol = m_vol[rd_voice];
      e_state = m_state[rd_voice]; e_cycle = m_cycle[rd_voice];
    end
`ifdef SPU_ADSR_CPU_READBACK_EN
    e_cpu = (rst || int'(cpu_rd) >= NV) ? 0 : m_vol[cpu_rd];
`else
    e_cpu = 0;
`endif
    @(posedge clk);
    #1;
    chk("kon",   o_kon,     e_kon);
    chk("vol",   o_vol,     e_vol);
    chk("state", o_state,   e_state);
    chk("cycle", o_cycle,   e_cycle);
    chk("cpu",   o_cpu_vol, e_cpu);
    idle();
  endtask

  task automatic wb(input int v, input bit uv, input bit us, input bit ck,
                    input int st, input int vol, input int cyc);
    wb_valid = 1; wb_voice = 5'(v); upd_vol = uv; upd_state = us; clr_kon = ck;
    n_state = 2'(st); n_vol = 15'(vol); n_cycle = 23'(cyc);
  endtask

  initial begin
    rst = 1; en = 1; rd_voice = '0; cpu_rd = '0;
    idle();
    model_reset();
    step(); step();
    rst = 0;

    // Reset contents of every voice plus an out-of-range index.
    for (int v = 0; v < NV; v++) begin
      rd_voice = 5'(v); cpu_rd = 5'(v);
      step();
    end
    rd_voice = 5'd25; cpu_rd = 5'd25;
    step();
    chk("lit_oor_state", o_state, 3);

    // Key-on voices 0 and 2, read voice 0 in the same cycle.
    kon_w = 1; key_mask = 24'h000005; rd_voice = 5'd0; cpu_rd = 5'd0;
    step();
    chk("lit_kon0_kon", o_kon, 1);
    chk("lit_kon0_cycle", o_cycle, 1);
    chk("lit_kon0_state", o_state, 0);
    rd_voice = 5'd2; step();
    rd_voice = 5'd1; step();
    chk("lit_v1_kon", o_kon, 0);

    // Write-back on voice 2 with all fields.
    wb(2, 1, 1, 1, 1, 'h1234, 100); rd_voice = 5'd2; cpu_rd = 5'd2;
    step();
    chk("lit_wb2_vol", o_vol, 'h1234);
    chk("lit_wb2_cycle", o_cycle, 100);
    chk("lit_wb2_state", o_state, 1);
    chk("lit_wb2_kon", o_kon, 0);

    // Voice 3: give it a volume, then key-off collides with a write-back.
    wb(3, 1, 1, 0, 2, 'h0555, 40); rd_voice = 5'd3; cpu_rd = 5'd3;
    step();
    wb(3, 1, 1, 0, 1, 'h7FFF, 77); koff_w = 1; key_mask = 24'h000008; rd_voice = 5'd3;
    step();
    chk("lit_koff3_vol", o_vol, 'h0555);
    chk("lit_koff3_state", o_state, 3);
    chk("lit_koff3_cycle", o_cycle, 1);

    // Key-on and key-off together on voice 5.
    kon_w = 1; koff_w = 1; key_mask = 24'h000020; rd_voice = 5'd5;
    step();
    chk("lit_v5_kon", o_kon, 0);
    chk("lit_v5_state", o_state, 3);

    // SPU disabled: key-on ignored, write-back and key-off accepted.
    en = 0; kon_w = 1; key_mask = 24'h000040; rd_voice = 5'd6;
    step();
    chk("lit_v6_kon", o_kon, 0);
    wb(6, 1, 0, 0, 0, 'h0011, 5); rd_voice = 5'd6; cpu_rd = 5'd6;
    step();
    koff_w = 1; key_mask = 24'h000040; rd_voice = 5'd6;
    step();
    en = 1;

    // Write-back to voice 8 and key-on of voice 9 in the same cycle.
    wb(8, 1, 1, 0, 2, 'h0ABC, 300); kon_w = 1; key_mask = 24'h000200; rd_voice = 5'd8;
    step();
    rd_voice = 5'd9; cpu_rd = 5'd8; step();
    chk("lit_v9_kon", o_kon, 1);

    // Out-of-range write-back is ignored; reads of voice 31 give reset values.
    wb(30, 1, 1, 1, 0, 'h7777, 123); rd_voice = 5'd31; cpu_rd = 5'd31;
    step();

    // Reset between two write-backs on voice 7.
    wb(7, 1, 1, 0, 2, 'h2222, 50); rd_voice = 5'd7; cpu_rd = 5'd7;
    step();
    rst = 1; wb(7, 1, 1, 0, 1, 'h3333, 60); rd_voice = 5'd7;
    step();
    chk("lit_rst_vol", o_vol, 0);
    rst = 0;
    wb(7, 0, 0, 0, 0, 0, 9); rd_voice = 5'd7; cpu_rd = 5'd7;
    step();
    chk("lit_v7_cycle", o_cycle, 9);
    chk("lit_v7_vol", o_vol, 0);
    chk("lit_v7_state", o_state, 3);
    wb(7, 1, 0, 0, 0, 'h0042, 8); rd_voice = 5'd7; cpu_rd = 5'd7;
    step();

    // Sweep all voices for final contents.
    for (int v = 0; v < NV; v++) begin
      rd_voice = 5'(v); cpu_rd = 5'(NV - 1 - v);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
